// File: rtl/pipeline_pkg.sv
// Shared pipeline types and defaults used by the fetch stage and its IF/ID register.
// Optional build macro used by the fetch stage: IF_FETCH_STATS_EN.
package pipeline_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {FETCH, WAIT, HOLD, DRAIN} fetch_state_e;

    localparam word_t RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam word_t NOP_INSTR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus: one request pulse, response some cycles later.
interface if_fetch_stage_if;
    import pipeline_pkg::*;

    logic  req;
    word_t addr;
    logic  rvalid;
    word_t rdata;

    modport master (output req, addr, input rvalid, rdata);
    modport slave  (input req, addr, output rvalid, rdata);

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble insert beats load, otherwise contents hold.
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  bubble,
    input  word_t pc,
    input  word_t instr,
    output word_t pc_id,
    output word_t pcplus4_id,
    output word_t instr_id,
    output logic  valid_id
);

    // A bubble keeps PC_id/PCPlus4_id so decode still sees the last real PC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_id      <= '0;
            pcplus4_id <= '0;
            instr_id   <= NOP_INSTR;
            valid_id   <= 1'b0;
        end else if (bubble) begin
            instr_id   <= NOP_INSTR;
            valid_id   <= 1'b0;
        end else if (load) begin
            pc_id      <= pc;
            pcplus4_id <= pc + 32'd4;
            instr_id   <= instr;
            valid_id   <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC, one-outstanding imem sequencing, hold buffer, IF/ID register.
// Define IF_FETCH_STATS_EN to add fetch_count / bubble_count outputs.
module if_fetch_stage
    import pipeline_pkg::*;
#(
    parameter word_t RESET_PC  = RESET_PC_DEFAULT,
    parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  PCWrite,
    input  logic  IFIDWrite,
    input  logic  flush,
    input  logic  Branch,
    input  word_t BranchTarget,
    input  word_t JumpTarget,
    if_fetch_stage_if.master imem,
    output word_t PC_id,
    output word_t PCPlus4_id,
    output word_t Instr_id,
    output logic  Valid_id
`ifdef IF_FETCH_STATS_EN
    ,
    output word_t fetch_count,
    output word_t bubble_count
`endif
);

    fetch_state_e state, state_nxt;
    word_t        pc, pc_nxt, buf_q, buf_nxt, redirect, ifid_instr;
    logic         buf_vld, buf_vld_nxt, ifid_load, ifid_bubble;

    assign redirect  = Branch ? {BranchTarget[31:2], 2'b00} : {JumpTarget[31:2], 2'b00};
    assign imem.addr = pc;
    assign imem.req  = rst && (state == FETCH) && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            buf_q   <= NOP_INSTR;
            buf_vld <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            buf_q   <= buf_nxt;
            buf_vld <= buf_vld_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        buf_nxt     = buf_q;
        buf_vld_nxt = buf_vld;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_instr  = buf_q;
        if (flush) begin
            pc_nxt      = redirect;
            ifid_bubble = 1'b1;
            buf_vld_nxt = 1'b0;
            // A response still owed by memory must be swallowed before refetching.
            state_nxt   = ((state == WAIT || state == DRAIN) && !imem.rvalid) ? DRAIN : FETCH;
        end else begin
            case (state)
                FETCH: state_nxt = WAIT;
                WAIT: if (imem.rvalid) begin
                    state_nxt = HOLD;
                    if (IFIDWrite) begin
                        ifid_load  = 1'b1;
                        ifid_instr = imem.rdata;
                        if (PCWrite) begin
                            pc_nxt    = pc + 32'd4;
                            state_nxt = FETCH;
                        end
                    end else begin
                        buf_nxt     = imem.rdata;
                        buf_vld_nxt = 1'b1;
                    end
                end
                HOLD: begin
                    if (IFIDWrite && buf_vld) begin
                        ifid_load   = 1'b1;
                        buf_vld_nxt = 1'b0;
                    end
                    // Never advance past a word that has not reached IF/ID yet.
                    if (PCWrite && (IFIDWrite || !buf_vld)) begin
                        pc_nxt    = pc + 32'd4;
                        state_nxt = FETCH;
                    end
                end
                DRAIN: if (imem.rvalid) state_nxt = FETCH;
                default: state_nxt = FETCH;
            endcase
        end
    end

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load       (ifid_load),
        .bubble     (ifid_bubble),
        .pc         (pc),
        .instr      (ifid_instr),
        .pc_id      (PC_id),
        .pcplus4_id (PCPlus4_id),
        .instr_id   (Instr_id),
        .valid_id   (Valid_id)
    );

`ifdef IF_FETCH_STATS_EN
    logic kill;
    assign kill = imem.rvalid && (state == DRAIN || (flush && state == WAIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count  <= '0;
            bubble_count <= '0;
        end else begin
            fetch_count  <= fetch_count + {31'b0, ifid_load};
            bubble_count <= bubble_count + {31'b0, flush} + {31'b0, kill};
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: transaction-level fetch model feeds an expectation queue.
module tb_if_fetch_stage;
    import pipeline_pkg::*;

    localparam word_t NOP = 32'h0000_0013;

    logic  clk = 1'b0, rst = 1'b0;
    logic  PCWrite = 1'b1, IFIDWrite = 1'b1, flush = 1'b0, Branch = 1'b0;
    word_t BranchTarget = '0, JumpTarget = '0;
    word_t PC_id, PCPlus4_id, Instr_id;
    logic  Valid_id;
`ifdef IF_FETCH_STATS_EN
    word_t fetch_count, bubble_count;
`endif

    if_fetch_stage_if imem();

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk          (clk),
        .rst          (rst),
        .PCWrite      (PCWrite),
        .IFIDWrite    (IFIDWrite),
        .flush        (flush),
        .Branch       (Branch),
        .BranchTarget (BranchTarget),
        .JumpTarget   (JumpTarget),
        .imem         (imem.master),
        .PC_id        (PC_id),
        .PCPlus4_id   (PCPlus4_id),
        .Instr_id     (Instr_id),
        .Valid_id     (Valid_id)
`ifdef IF_FETCH_STATS_EN
        ,
        .fetch_count  (fetch_count),
        .bubble_count (bubble_count)
`endif
    );

    typedef struct {
        logic  req;
        word_t addr, pcid, pcp4, instr;
        logic  valid;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_bad = 0;

    // Reference model: architectural fetch state, not cycle states.
    word_t m_pc, m_pcid, m_pcp4, m_instr, m_word;
    bit    m_valid, m_busy, m_stale, m_got, m_pend;
    // Memory behaviour driven by the bench.
    bit    mem_pend, force_rv, spur_en, mem_const;
    int    mem_left, lat_min, lat_max;
    word_t mem_addr;

    task automatic chk(input string nm, input word_t act, input word_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic word_t mdata(input word_t a);
        return mem_const ? 32'h2001_0005 : (a ^ 32'h9E37_79B9);
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_pcid = '0; m_pcp4 = '0; m_instr = NOP; m_word = '0;
        m_valid = 0; m_busy = 0; m_stale = 0; m_got = 0; m_pend = 0;
        mem_pend = 0; mem_left = 0; mem_addr = '0;
    endtask

    // Called at posedge+1: drive this cycle, queue expectations, advance model, wait one clock.
    task automatic cyc(input bit pcw, input bit ifw, input bit fl, input bit br,
                       input word_t bt, input word_t jt);
        bit    rv;
        word_t rd;
        exp_t  e;
        rv = 0;
        rd = $urandom;
        if (mem_pend) begin
            mem_left--;
            if (mem_left == 0) begin rv = 1; rd = mdata(mem_addr); mem_pend = 0; end
        end else if (force_rv) begin
            rv = 1; force_rv = 0;
        end else if (spur_en && !m_busy && $urandom_range(7) == 0) begin
            rv = 1;
        end
        imem.rvalid = rv; imem.rdata = rd;
        PCWrite = pcw; IFIDWrite = ifw; flush = fl; Branch = br;
        BranchTarget = bt; JumpTarget = jt;

        e.req = !m_busy && !m_got && !fl;
        e.addr = m_pc; e.pcid = m_pcid; e.pcp4 = m_pcp4; e.instr = m_instr; e.valid = m_valid;
        sb.push_back(e);
        if (e.req) begin
            mem_pend = 1; mem_addr = m_pc; mem_left = $urandom_range(lat_max, lat_min);
        end

        if (fl) begin
            m_pc = (br ? bt : jt) & 32'hFFFF_FFFC;
            m_instr = NOP; m_valid = 0;
            m_got = 0; m_pend = 0;
            m_stale = m_busy && !rv;
            m_busy  = m_busy && !rv;
        end else begin
            if (m_busy) begin
                if (rv) begin
                    m_busy = 0;
                    if (m_stale) m_stale = 0;
                    else begin m_got = 1; m_pend = 1; m_word = rd; end
                end
            end else if (e.req) begin
                m_busy = 1;
            end
            if (m_got) begin
                if (m_pend && ifw) begin
                    m_pcid = m_pc; m_pcp4 = m_pc + 32'd4; m_instr = m_word; m_valid = 1; m_pend = 0;
                end
                if (pcw && !m_pend) begin m_pc = m_pc + 32'd4; m_got = 0; end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cyc(1, 1, 0, 0, '0, '0);
    endtask

    // Step until the model has a fresh request outstanding (a memory wait cycle).
    task automatic to_wait();
        int g;
        g = 0;
        while (m_busy && g < 20) begin cyc(1, 1, 0, 0, '0, '0); g++; end
        while (!m_busy && g < 40) begin cyc(1, 1, 0, 0, '0, '0); g++; end
        chk("reach_wait", {31'b0, m_busy}, 32'h1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req",     {31'b0, imem.req}, 32'h0);
        chk("rst_addr",    imem.addr, 32'h0);
        chk("rst_pc_id",   PC_id, 32'h0);
        chk("rst_pcp4_id", PCPlus4_id, 32'h0);
        chk("rst_instr",   Instr_id, NOP);
        chk("rst_valid",   {31'b0, Valid_id}, 32'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("imem_req",   {31'b0, imem.req}, {31'b0, e.req});
                chk("imem_addr",  imem.addr, e.addr);
                chk("PC_id",      PC_id, e.pcid);
                chk("PCPlus4_id", PCPlus4_id, e.pcp4);
                chk("Instr_id",   Instr_id, e.instr);
                chk("Valid_id",   {31'b0, Valid_id}, {31'b0, e.valid});
            end
        end
    end

    initial begin : stim
        bit fl;
        imem.rvalid = 0; imem.rdata = '0;
        model_reset();
        force_rv = 0; spur_en = 0; mem_const = 1; lat_min = 1; lat_max = 1;
        #12;
        chk_reset_outputs();
        @(posedge clk); #1;
        rst = 1;

        // Single-cycle memory, constant word: addresses 0,4,8,...
        run(7);

        // Stall both controls while the response lands, then release.
        to_wait();
        repeat (3) cyc(0, 0, 0, 0, '0, '0);
        run(4);
        // Response accepted with PC held: no refetch on release.
        to_wait();
        cyc(0, 1, 0, 0, '0, '0);
        cyc(0, 1, 0, 0, '0, '0);
        run(4);

        // Branch flush with a slow request outstanding.
        mem_const = 0; lat_min = 3; lat_max = 3;
        to_wait();
        cyc(1, 1, 1, 1, 32'h0000_0040, 32'h0000_0999);
        run(8);

        // Jump with unaligned target, then wrap at the top of memory.
        lat_min = 1; lat_max = 1;
        cyc(1, 1, 1, 0, 32'h0000_0777, 32'h0000_0103);
        run(5);
        cyc(1, 1, 1, 0, '0, 32'hFFFF_FFFC);
        run(6);

        // Asynchronous reset in the middle of a memory wait.
        lat_min = 3; lat_max = 3;
        to_wait();
        #2 rst = 0;
        sb.delete();
        #1;
        chk_reset_outputs();
        imem.rvalid = 0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1;
        model_reset();
        force_rv = 1;
        lat_min = 1; lat_max = 2;
        run(8);

        // Randomized traffic.
        lat_min = 1; lat_max = 3; spur_en = 1;
        repeat (600) begin
            fl = ($urandom_range(9) == 0);
            cyc($urandom_range(3) != 0, $urandom_range(3) != 0, fl,
                1'($urandom_range(1)), $urandom, $urandom);
        end
        spur_en = 0;
        run(4);
        #5;
        chk("sb_drained", sb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline: PC register, instruction-memory request/response sequencing, a one-entry fetch hold buffer, and the IF/ID pipeline register.
- Consumes PCWrite, IFIDWrite and flush from the hazard detector, plus the branch/jump redirect from ID.
- Produces PC_id, Instr_id and Valid_id for the decode stage.
- Tolerates variable-latency instruction memory with at most one request outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID as a bubble.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- PCWrite  input  1  1 = PC may advance; 0 = hold (load-use stall).
- IFIDWrite  input  1  1 = IF/ID may load; 0 = hold IF/ID contents.
- flush  input  1  redirect plus kill of the in-flight fetch (Branch or Jump taken).
- Branch  input  1  branch taken this cycle (qualifies BranchTarget).
- BranchTarget  input  32  branch destination.
- JumpTarget  input  32  jump destination, used when flush=1 and Branch=0.
- imem_req  output  1  request pulse, one cycle; address valid in the same cycle.
- imem_addr  output  32  fetch address (word aligned).
- imem_rvalid  input  1  response valid; arrives at least 1 cycle after imem_req.
- imem_rdata  input  32  instruction word, valid with imem_rvalid.
- PC_id  output  32  PC of the instruction held in IF/ID.
- PCPlus4_id  output  32  PC_id + 4.
- Instr_id  output  32  instruction held in IF/ID.
- Valid_id  output  1  1 = Instr_id is a real instruction; 0 = bubble.

Behaviour:
- Reset (rst=0, asynchronous):
  - PC=RESET_PC; state=FETCH; imem_req=0.
  - PC_id=0, PCPlus4_id=0, Instr_id=NOP_INSTR, Valid_id=0; kill flag cleared; hold buffer invalid.
  - First imem_req is issued in the first cycle after rst deasserts.
- imem_addr = PC at all times. imem_req is high only in FETCH when no flush is present. At most one request is outstanding.
- State FETCH:
  - Assert imem_req; go to WAIT.
- State WAIT:
  - Wait for imem_rvalid.
  - On rvalid with IFIDWrite=1: load IF/ID with {PC, rdata}, Valid_id=1.
    - If PCWrite=1, PC <= PC+4 and go to FETCH.
    - If PCWrite=0, go to HOLD with the buffer marked consumed; resume FETCH when PCWrite=1 without refetching.
  - On rvalid with IFIDWrite=0: capture rdata into the hold buffer; go to HOLD.
- State HOLD:
  - No requests issued.
  - When IFIDWrite=1, load IF/ID from the buffer.
  - When PCWrite=1, PC <= PC+4 and go to FETCH.
  - The buffer may load in a cycle earlier than the PC update.
- State DRAIN:
  - Wait for the killed response. On rvalid, discard it and go to FETCH.
- flush=1, in any state (highest priority in this block, including over PCWrite=0 and IFIDWrite=0):
  - PC <= Branch ? BranchTarget : JumpTarget.
  - IF/ID <= {PC_id unchanged, NOP_INSTR}, Valid_id=0.
  - Hold buffer invalidated.
  - If a request is outstanding (WAIT with no rvalid this cycle), go to DRAIN.
  - Otherwise go to FETCH; any rvalid arriving in the flush cycle is discarded.
- Stall (IFIDWrite=0): PC_id, PCPlus4_id, Instr_id and Valid_id hold their values.
- Arithmetic and width rules:
  - PC+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 0.
  - Target bits [1:0] are forced to 0.
- Latency: with single-cycle memory and no stalls, one instruction enters IF/ID every 2 cycles (FETCH→WAIT).
- imem_rvalid is ignored in FETCH and HOLD.

Optional Feature:
- Macro: IF_FETCH_STATS_EN.
- When defined, adds two outputs:
  - fetch_count (32): increments on every instruction loaded into IF/ID with Valid_id=1.
  - bubble_count (32): increments on every flush cycle and every killed response.
  - Both reset to 0 and wrap modulo 2^32.
- When undefined, neither port nor any counter logic exists.

Decomposition:
- Shared package (pipeline_pkg) holds:
  - the fetch-state enum {FETCH, WAIT, HOLD, DRAIN};
  - the NOP_INSTR default;
  - the RESET_PC default;
  - the 32-bit word type.
- One natural sub-module: if_id_reg, the IF/ID register with load, hold and bubble-insert controls. The FSM and PC logic stay in the top module.

Test Plan:
- Reset release, memory returns 32'h2001_0005 with 1-cycle latency -> imem_addr sequence 0,4,8; Instr_id=32'h2001_0005, Valid_id=1, PC_id=0.
- IFIDWrite=0 and PCWrite=0 for 3 cycles while an rvalid arrives -> IF/ID unchanged, no imem_req; after release IF/ID gets the buffered word with no refetch of the same PC.
- flush=1, Branch=1, BranchTarget=32'h0000_0040 with a request outstanding -> DRAIN; late rvalid discarded; next imem_addr=32'h40; Valid_id=0 for the flush cycle.
- flush=1, Branch=0, JumpTarget=32'h0000_0103 -> next fetch address 32'h100.
- PC=32'hFFFF_FFFC fetched, no stall -> next imem_addr=0.
- rst asserted while in WAIT -> outputs return to reset values immediately; a stale rvalid after release is ignored until the first new request.
